// File: rtl/pipe_mult_acc_n.sv
`timescale 1ns/1ps
// pipe_mult_acc_n
//   Pipelined N x N multiplier (signed or unsigned per sample) feeding a
//   sticky-overflow accumulator. A sample accepted on edge k shows up on p at
//   edge k+LAT; an accumulate lands on acc one edge after that.
//
//   Optional feature: define PIPE_MULT_ACC_SAT_EN to make the accumulator
//   saturate instead of wrapping.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in_valid  in   qualifies a, b, sgn, acc_en, clr
//   a, b      in   N-bit operands
//   sgn       in   1 = two's-complement operands, 0 = unsigned
//   acc_en    in   add this sample's product into the accumulator
//   clr       in   clear acc and ovf (takes effect on the accepting edge)
//   out_valid out  one-cycle pulse, p holds a new product
//   p         out  2*N-bit registered product
//   acc       out  ACC_W-bit registered accumulator
//   acc_valid out  one-cycle pulse, acc updated by a sample
//   ovf       out  sticky overflow flag
module pipe_mult_acc_n #(
  parameter int unsigned N     = 8,
  parameter int unsigned LAT   = 2,
  parameter int unsigned ACC_W = 2*N+4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  input  logic               sgn,
  input  logic               acc_en,
  input  logic               clr,
  output logic               out_valid,
  output logic [2*N-1:0]     p,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_valid,
  output logic               ovf
);

  // Stage 0 is the operand capture register; stages 1..LAT carry the product.
  logic [LAT:0]     vld;
  logic [LAT:0]     sg;
  logic [LAT:0]     ae;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [2*N-1:0]   pr [1:LAT];

  logic [2*N-1:0]   a_ext;
  logic [2*N-1:0]   b_ext;
  logic [2*N-1:0]   prod;

  // Sign/zero extending to 2N bits makes the low 2N bits of the product
  // correct for both signed and unsigned operands.
  always_comb begin
    a_ext = sg[0] ? {{N{a_q[N-1]}}, a_q} : {{N{1'b0}}, a_q};
    b_ext = sg[0] ? {{N{b_q[N-1]}}, b_q} : {{N{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Data registers load only behind a valid, so bubbles leave p unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      sg  <= '0;
      ae  <= '0;
      a_q <= '0;
      b_q <= '0;
      for (int unsigned i = 1; i <= LAT; i++) pr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        a_q   <= a;
        b_q   <= b;
        sg[0] <= sgn;
        ae[0] <= acc_en;
      end
      vld[1] <= vld[0];
      if (vld[0]) begin
        pr[1] <= prod;
        sg[1] <= sg[0];
        ae[1] <= ae[0];
      end
      for (int unsigned i = 2; i <= LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          pr[i] <= pr[i-1];
          sg[i] <= sg[i-1];
          ae[i] <= ae[i-1];
        end
      end
    end
  end

  assign out_valid = vld[LAT];
  assign p         = pr[LAT];

  logic             clr_now;
  logic             upd;
  logic [ACC_W-1:0] ext_p;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] nxt;
  logic             carry;
  logic             sov;
  logic             ov;

  // A clear on the same edge as an update zeroes the base first.
  always_comb begin
    clr_now = in_valid & clr;
    upd     = out_valid & ae[LAT];
    ext_p   = sg[LAT] ? ACC_W'($signed(p)) : ACC_W'(p);
    base    = clr_now ? '0 : acc;
    {carry, sum} = {1'b0, base} + {1'b0, ext_p};
    sov     = (base[ACC_W-1] == ext_p[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    ov      = sg[LAT] ? sov : carry;
`ifdef PIPE_MULT_ACC_SAT_EN
    if (ov) begin
      if (sg[LAT]) nxt = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else         nxt = '1;
    end else begin
      nxt = sum;
    end
`else
    nxt     = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= upd;
      if (upd) begin
        acc <= nxt;
        ovf <= (ovf & ~clr_now) | ov;
      end else if (clr_now) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pipe_mult_acc_n.md
PIPE_MULT_ACC_N -- requirements
Module: pipe_mult_acc_n

Interface
REQ-001 Parameter N, default 8, operand width in bits (2..32).
REQ-002 Parameter LAT, default 2, multiplier pipeline depth in cycles (1..4).
REQ-003 Parameter ACC_W, default 2*N+4, accumulator width in bits (at least 2*N).
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  qualifies a, b, sgn, acc_en and clr for this cycle.
REQ-007 a, b  in  N each  multiplier operands.
REQ-008 sgn  in  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-009 acc_en  in  1  1 = add this sample's product into the accumulator.
REQ-010 clr  in  1  clears the accumulator and the overflow flag.
REQ-011 out_valid  out  1  one-cycle pulse when p holds a new product.
REQ-012 p  out  2*N  registered product.
REQ-013 acc  out  ACC_W  registered accumulator.
REQ-014 acc_valid  out  1  one-cycle pulse when acc has been updated by a sample.
REQ-015 ovf  out  1  sticky accumulator overflow flag.

Function
REQ-016 When in_valid=1, the block SHALL capture a, b, sgn and acc_en; there is no backpressure and a new sample is accepted every cycle.
REQ-017 The product of a sample captured at edge k SHALL appear on p with out_valid=1 exactly at edge k+LAT; samples SHALL never reorder or merge.
REQ-018 The product SHALL be a full 2*N-bit result: a signed product when the sample's sgn=1, an unsigned product when sgn=0.
REQ-019 When in_valid=0, a pipeline bubble SHALL be inserted: out_valid=0 and p holds its last value.
REQ-020 When out_valid=1 with the carried acc_en=1, acc SHALL update one edge later to acc + ext(p), and acc_valid SHALL pulse for that edge.
REQ-021 ext() SHALL sign-extend p to ACC_W when the carried sgn=1 and zero-extend it otherwise.
REQ-022 Without saturation, the accumulator SHALL wrap modulo 2^ACC_W; ovf SHALL set on signed overflow when sgn=1 and on unsigned carry-out when sgn=0.
REQ-023 clr takes effect on the edge it is sampled with in_valid=1; it SHALL set acc=0 and ovf=0 and does not affect samples already in the pipeline.
REQ-024 If clr and an accumulate update land on the same edge, the clear SHALL take effect first, so acc = ext(p) and ovf is computed from zero.
REQ-025 ovf SHALL remain set until clr or reset.

Reset
REQ-026 On reset=1 at an edge: all pipeline valid bits, out_valid, acc_valid and ovf SHALL go to 0, and p and acc SHALL go to 0.
REQ-027 Reset during operation SHALL discard every in-flight sample; no out_valid pulse SHALL occur for a sample accepted before or during reset.
REQ-028 Reset SHALL take priority over in_valid and clr in the same cycle.

Configuration
REQ-029 Macro PIPE_MULT_ACC_SAT_EN, when defined, SHALL make the accumulator saturate instead of wrap.
REQ-030 Saturation targets: the signed maximum or minimum of ACC_W bits when sgn=1; 2^ACC_W-1 when sgn=0. ovf SHALL set whenever saturation occurs.
REQ-031 When PIPE_MULT_ACC_SAT_EN is undefined, the accumulator SHALL wrap as in REQ-022, with no saturation logic synthesised.

Verification
REQ-032 (N=8, LAT=2) Unsigned 255*255 at edge 0 -> p=0xFE01 with out_valid=1 at edge 2 only.
REQ-033 Signed -128*-128 then -1*1 on back-to-back cycles -> p=0x4000, then p=0xFFFF on consecutive cycles.
REQ-034 Samples 3*4, 5*6, 7*8 back-to-back, acc_en=1, clr=1 on the first -> acc=12, 42, 98 with three acc_valid pulses.
REQ-035 (ACC_W=16) Two unsigned 255*255 accumulates -> wrap build: acc=0xFC02, ovf=1; SAT build: acc=0xFFFF, ovf=1; then clr with 1*1 -> acc=1, ovf=0.
REQ-036 Reset asserted one cycle after accepting 9*9 -> no out_valid pulse, and p=0, acc=0, ovf=0 after reset.
